// File: rtl/rf_frame_packer.sv
// RF ADC sample capture into frame-aligned AXI-Stream beats via a small show-ahead FIFO.
// Optional build macro RF_OFFSET_BINARY_EN: treat adc_data as offset-binary instead of two's complement.
`timescale 1ns/1ps

// state     | meaning
// IDLE      | capture disarmed, waiting for enable
// WAIT_SYNC | armed, waiting for the firing frame_start pulse
// CAPTURE   | writing samples until FRAME_LEN have been stored
module rf_frame_packer #(
  parameter int ADC_WIDTH  = 12,
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN  = 24100,
  parameter int FIFO_AW    = 4
) (
  input  logic                  m00_axis_aclk,
  input  logic                  m00_axis_aresetn,
  input  logic                  enable,
  input  logic                  frame_start,
  input  logic [ADC_WIDTH-1:0]  adc_data,
  input  logic                  adc_valid,
  output logic [DATA_WIDTH-1:0] m00_axis_tdata,
  output logic                  m00_axis_tvalid,
  input  logic                  m00_axis_tready,
  output logic                  m00_axis_tlast,
  output logic                  overflow,
  output logic [15:0]           frame_count,
  output logic [FIFO_AW:0]      fifo_level
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_SYNC, CAPTURE} state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n, cur_cnt;
  logic [FIFO_AW:0]     wr_ptr, rd_ptr;
  logic [ADC_WIDTH:0]   mem [DEPTH];
  logic [ADC_WIDTH:0]   head;
  logic [ADC_WIDTH-1:0] sample;
  logic                 full, empty, win, wr_en, rd_en, drop, last_flag;

  assign full       = (wr_ptr == {~rd_ptr[FIFO_AW], rd_ptr[FIFO_AW-1:0]});
  assign empty      = (wr_ptr == rd_ptr);
  assign fifo_level = wr_ptr - rd_ptr;
  assign head       = mem[rd_ptr[FIFO_AW-1:0]];
  assign rd_en      = ~empty & (~m00_axis_tvalid | m00_axis_tready);

`ifdef RF_OFFSET_BINARY_EN
  assign sample = {~adc_data[ADC_WIDTH-1], adc_data[ADC_WIDTH-2:0]};
`else
  assign sample = adc_data;
`endif

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    cur_cnt   = cnt;
    win       = 1'b0;
    wr_en     = 1'b0;
    drop      = 1'b0;
    last_flag = 1'b0;
    case (state)
      IDLE: if (enable) state_n = WAIT_SYNC;
      WAIT_SYNC: begin
        if (!enable) begin
          state_n = IDLE;
        end else if (frame_start) begin
          win     = 1'b1;
          cur_cnt = '0;
          cnt_n   = '0;
          state_n = CAPTURE;
        end
      end
      CAPTURE: win = 1'b1;
      default: state_n = IDLE;
    endcase
    // full is judged on pre-edge pointers, so a same-cycle read never makes room
    wr_en     = win & adc_valid & ~full;
    drop      = win & adc_valid & full;
    last_flag = (cur_cnt == CNT_W'(FRAME_LEN - 1));
    if (wr_en) begin
      cnt_n = cur_cnt + CNT_W'(1);
      if (last_flag) begin
        cnt_n   = '0;
        state_n = enable ? WAIT_SYNC : IDLE;
      end
    end
  end

  always_ff @(posedge m00_axis_aclk) begin
    if (wr_en) mem[wr_ptr[FIFO_AW-1:0]] <= {last_flag, sample};
  end

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state           <= IDLE;
      cnt             <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      overflow        <= 1'b0;
      frame_count     <= '0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast  <= 1'b0;
      m00_axis_tdata  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (drop) overflow <= 1'b1;
      if (m00_axis_tvalid && m00_axis_tready && m00_axis_tlast)
        frame_count <= frame_count + 16'd1;
      if (rd_en) begin
        rd_ptr          <= rd_ptr + 1'b1;
        m00_axis_tvalid <= 1'b1;
        m00_axis_tlast  <= head[ADC_WIDTH];
        m00_axis_tdata  <= DATA_WIDTH'($signed(head[ADC_WIDTH-1:0]));
      end else if (m00_axis_tready) begin
        m00_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule
